// File: rtl/div32x16_seq.sv
// Sequential restoring divider: one quotient bit per clock, MSB first.
// Results and status flags are registered and held from done until the next accepted start.
module div32x16_seq #(
  parameter int DIVIDEND_W = 32,
  parameter int DIVISOR_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero,
  output logic                  q_ovf
);

  localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIVIDEND_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] shq_q, shq_d;   // dividend bits leave at the MSB, quotient bits enter at the LSB
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
  logic [DIVISOR_W:0]    part_q, part_d;
  logic                  zero_q, zero_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DIVIDEND_W-1:0] quo_q, quo_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic                  dbz_q, dbz_d;
  logic                  ovf_q, ovf_d;

  logic [DIVISOR_W:0]    part_sh_s;
  logic [DIVISOR_W:0]    part_nx_s;
  logic [DIVIDEND_W-1:0] shq_nx_s;
  logic                  ge_s;

  function automatic logic upper_nonzero(input logic [DIVIDEND_W-1:0] q);
    upper_nonzero = ((q >> DIVISOR_W) != {DIVIDEND_W{1'b0}});
  endfunction

  // One restoring step: shift in the next dividend bit, subtract when it fits.
  always_comb begin
    part_sh_s = {part_q[DIVISOR_W-1:0], shq_q[DIVIDEND_W-1]};
    ge_s      = (part_sh_s >= {1'b0, dvs_q});
    if (ge_s) begin
      part_nx_s = part_sh_s - {1'b0, dvs_q};
    end else begin
      part_nx_s = part_sh_s;
    end
    shq_nx_s = {shq_q[DIVIDEND_W-2:0], ge_s};
  end

  // Next-state, datapath and result capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shq_d   = shq_q;
    dvs_d   = dvs_q;
    part_d  = part_q;
    zero_d  = zero_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CALC;
          shq_d   = dividend;
          dvs_d   = divisor;
          part_d  = {(DIVISOR_W+1){1'b0}};
          cnt_d   = {CNT_W{1'b0}};
          zero_d  = (divisor == {DIVISOR_W{1'b0}});
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        // A zero divisor spends a single CALC cycle so that both paths report on the DONE-entry edge.
        if (zero_q) begin
          state_d = DONE;
          quo_d   = {DIVIDEND_W{1'b1}};
          rem_d   = shq_q[DIVISOR_W-1:0];
          dbz_d   = 1'b1;
          ovf_d   = 1'b1;
        end else begin
          shq_d  = shq_nx_s;
          part_d = part_nx_s;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_d = DONE;
            quo_d   = shq_nx_s;
            rem_d   = part_nx_s[DIVISOR_W-1:0];
            dbz_d   = 1'b0;
            ovf_d   = upper_nonzero(shq_nx_s);
          end else begin
            state_d = CALC;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      shq_q   <= {DIVIDEND_W{1'b0}};
      dvs_q   <= {DIVISOR_W{1'b0}};
      part_q  <= {(DIVISOR_W+1){1'b0}};
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= {DIVIDEND_W{1'b0}};
      rem_q   <= {DIVISOR_W{1'b0}};
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shq_q   <= shq_d;
      dvs_q   <= dvs_d;
      part_q  <= part_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign q_ovf       = ovf_q;

endmodule

// File: tb/tb_div32x16_seq.sv
// Self-checking bench for div32x16_seq: directed corner cases, reset mid-operation
// and randomized operands checked against a plain-arithmetic reference model.
module tb_div32x16_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;
  logic        q_ovf;

  int checks   = 0;
  int failures = 0;

  logic [31:0] prev_q;
  logic [15:0] prev_r;
  logic        prev_z;
  logic        prev_o;

  div32x16_seq dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .q_ovf      (q_ovf)
  );

  always #5 clk = ~clk;

  // Issue one division at a negedge, optionally pulse an ignored start at cycle inj,
  // and check hold behaviour, latency, results and the following IDLE cycle.
  task automatic do_div(input logic [31:0] a, input logic [15:0] b, input int inj);
    logic [31:0] exp_q;
    logic [15:0] exp_r;
    logic        exp_z;
    logic        exp_o;
    logic [31:0] b_ext;
    int          exp_lat;
    int          k;
    bit          got;
    b_ext = {16'd0, b};
    if (b == 16'd0) begin
      exp_q   = 32'hFFFF_FFFF;
      exp_r   = a[15:0];
      exp_z   = 1'b1;
      exp_o   = 1'b1;
      exp_lat = 1;
    end else begin
      exp_q   = a / b_ext;
      exp_r   = 16'(a % b_ext);
      exp_z   = 1'b0;
      exp_o   = (exp_q > 32'h0000_FFFF);
      exp_lat = 32;
    end
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; dividend = $urandom; divisor = 16'($urandom);
    k = 0; got = 1'b0;
    while (!got && k < 40) begin
      if (done === 1'b1) begin
        got = 1'b1;
      end else begin
        checks++;
        if (busy !== 1'b1 || quotient !== prev_q || remainder !== prev_r ||
            div_by_zero !== prev_z || q_ovf !== prev_o) begin
          failures++;
          $display("FAIL hold_calc a=%h b=%h k=%0d: got busy=%b q=%h r=%h dbz=%b ovf=%b, want busy=1 q=%h r=%h dbz=%b ovf=%b",
                   a, b, k, busy, quotient, remainder, div_by_zero, q_ovf, prev_q, prev_r, prev_z, prev_o);
        end
        start = (k == inj);
        if (k == inj) begin
          dividend = 32'd50; divisor = 16'd5;
        end
        @(negedge clk);
        k++;
      end
    end
    start = 1'b0;
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL done_timeout a=%h b=%h: no done within 40 cycles", a, b);
    end else begin
      if (k != exp_lat) begin
        failures++;
        $display("FAIL latency a=%h b=%h: got %0d cycles, want %0d", a, b, k, exp_lat);
      end
      checks++;
      if (quotient !== exp_q || remainder !== exp_r || div_by_zero !== exp_z ||
          q_ovf !== exp_o || busy !== 1'b1) begin
        failures++;
        $display("FAIL result a=%h b=%h: got q=%h r=%h dbz=%b ovf=%b busy=%b, want q=%h r=%h dbz=%b ovf=%b busy=1",
                 a, b, quotient, remainder, div_by_zero, q_ovf, busy, exp_q, exp_r, exp_z, exp_o);
      end
    end
    prev_q = exp_q; prev_r = exp_r; prev_z = exp_z; prev_o = exp_o;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || quotient !== prev_q || remainder !== prev_r ||
        div_by_zero !== prev_z || q_ovf !== prev_o) begin
      failures++;
      $display("FAIL after_done a=%h b=%h: got done=%b busy=%b q=%h r=%h dbz=%b ovf=%b, want done=0 busy=0 q=%h r=%h",
               a, b, done, busy, quotient, remainder, div_by_zero, q_ovf, prev_q, prev_r);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; dividend = 32'd0; divisor = 16'd0;
    prev_q = 32'd0; prev_r = 16'd0; prev_z = 1'b0; prev_o = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== 32'd0 || remainder !== 16'd0 ||
        div_by_zero !== 1'b0 || q_ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got busy=%b done=%b q=%h r=%h dbz=%b ovf=%b, want all 0",
               busy, done, quotient, remainder, div_by_zero, q_ovf);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    do_div(32'hFFFE_0001, 16'hFFFF, -1);
    do_div(32'd100,       16'd7,    -1);
    do_div(32'h1234_5678, 16'd0,    -1);
    do_div(32'h0001_0000, 16'd1,    -1);
    do_div(32'hFFFF_FFFF, 16'd1,    -1);
    do_div(32'd5,         16'd9,    -1);
    do_div(32'hFFFF_FFFF, 16'hFFFF, -1);
    do_div(32'd0,         16'd0,    -1);
  endtask

  task automatic test_ignored_start();
    do_div(32'd100, 16'd7, 10);
    do_div(32'd0,   16'd0, 0);
  endtask

  task automatic test_reset_mid_calc();
    bit seen_done;
    start = 1'b1; dividend = 32'd100; divisor = 16'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (k == 10) begin
        start = 1'b1; dividend = 32'd50; divisor = 16'd5;
      end else begin
        start = 1'b0;
      end
      checks++;
      if (done !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL mid_calc_busy k=%0d: got done=%b busy=%b, want done=0 busy=1", k, done, busy);
      end
      @(negedge clk);
    end
    start = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== 32'd0 || remainder !== 16'd0 ||
        div_by_zero !== 1'b0 || q_ovf !== 1'b0) begin
      failures++;
      $display("FAIL mid_calc_reset: got busy=%b done=%b q=%h r=%h dbz=%b ovf=%b, want all 0",
               busy, done, quotient, remainder, div_by_zero, q_ovf);
    end
    @(negedge clk);
    reset = 1'b0;
    prev_q = 32'd0; prev_r = 16'd0; prev_z = 1'b0; prev_o = 1'b0;
    seen_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || quotient !== 32'd0) seen_done = 1'b1;
    end
    checks++;
    if (seen_done) begin
      failures++;
      $display("FAIL no_done_after_reset: got activity after reset, want idle with zero outputs");
    end
    do_div(32'd9, 16'd4, -1);
    checks++;
    if (quotient !== 32'd2 || remainder !== 16'd1) begin
      failures++;
      $display("FAIL post_reset_9_4: got q=%0d r=%0d, want q=2 r=1", quotient, remainder);
    end
  endtask

  task automatic test_mult_inverse();
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] prod;
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom_range(0, 65535));
      b = 16'($urandom_range(1, 65535));
      prod = {16'd0, a} * {16'd0, b};
      do_div(prod, b, -1);
      checks++;
      if (quotient !== {16'd0, a} || remainder !== 16'd0 || q_ovf !== 1'b0) begin
        failures++;
        $display("FAIL mult_inverse a=%h b=%h: got q=%h r=%h ovf=%b, want q=%h r=0 ovf=0",
                 a, b, quotient, remainder, q_ovf, a);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [15:0] b;
    for (int i = 0; i < 150; i++) begin
      a = $urandom;
      b = (i % 10 == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
      do_div(a, b, (i % 7 == 0) ? int'($urandom_range(0, 31)) : -1);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignored_start();
    test_reset_mid_calc();
    test_mult_inverse();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
